// File: rtl/flash_pkg.sv
// Shared types and defaults for the flowing-LED controller stages.
package flash_pkg;

    typedef logic [1:0] speed_lvl_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam int DEF_DEB_CYCLES = 2_000_000;
    localparam int DEF_PERIOD0    = 50_000_000;
    localparam int DEF_PERIOD1    = 25_000_000;
    localparam int DEF_PERIOD2    = 12_500_000;
    localparam int DEF_PERIOD3    = 6_250_000;
    localparam int DEF_CNT_W      = 26;

    // The LED shifter loads this on reset; kept here so both stages agree.
    localparam logic [7:0] LED_RESET_PATTERN = 8'h80;

endpackage

// File: rtl/flash_tick_gen_if.sv
// Button inputs, power gate and step/direction/speed outputs of the tick generator.
interface flash_tick_gen_if;

    logic                   btn_dir;
    logic                   btn_speed;
    logic                   power_now;
    logic                   clk_bps;
    logic                   dir;
    flash_pkg::speed_lvl_t  speed_lvl;

    modport master (
        output btn_dir, btn_speed, power_now,
        input  clk_bps, dir, speed_lvl
    );

    modport slave (
        input  btn_dir, btn_speed, power_now,
        output clk_bps, dir, speed_lvl
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, counter debounce and one-cycle press pulse for a raw button.
module btn_debounce #(
    parameter int DEB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          s1;
    logic          s2;
    logic          stable;
    logic          stable_d;
    logic [DW-1:0] dcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Any sample agreeing with the accepted level restarts the stability count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            dcnt   <= '0;
        end else if (s2 == stable) begin
            dcnt   <= '0;
        end else if (dcnt == DW'(DEB_CYCLES - 1)) begin
            stable <= s2;
            dcnt   <= '0;
        end else begin
            dcnt   <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d <= 1'b0;
            press    <= 1'b0;
        end else begin
            stable_d <= stable;
            press    <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/flash_tick_gen.sv
// Debounced direction/speed control plus the speed-selected step strobe for the LED shifter.
module flash_tick_gen
    import flash_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int PERIOD0    = DEF_PERIOD0,
    parameter int PERIOD1    = DEF_PERIOD1,
    parameter int PERIOD2    = DEF_PERIOD2,
    parameter int PERIOD3    = DEF_PERIOD3,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    flash_tick_gen_if.slave  bus
);

    logic             dir_press;
    logic             spd_press;
    logic [CNT_W-1:0] cnt;
    logic             bps_q;
    logic             dir_q;
    speed_lvl_t       speed_q;

    function automatic logic [CNT_W-1:0] period_m1(input speed_lvl_t lvl);
        case (lvl)
            2'd0:    return CNT_W'(PERIOD0 - 1);
            2'd1:    return CNT_W'(PERIOD1 - 1);
            2'd2:    return CNT_W'(PERIOD2 - 1);
            default: return CNT_W'(PERIOD3 - 1);
        endcase
    endfunction

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_dir),
        .press (dir_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_speed (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_speed),
        .press (spd_press)
    );

    // Presses while halted are dropped; the levels themselves are retained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q   <= DIR_RIGHT;
            speed_q <= '0;
        end else if (bus.power_now) begin
            if (dir_press) dir_q   <= ~dir_q;
            if (spd_press) speed_q <= speed_q + 1'b1;
        end
    end

    // A speed change restarts the period so the new rate starts from a clean phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            bps_q <= 1'b0;
        end else if (!bus.power_now || spd_press) begin
            cnt   <= '0;
            bps_q <= 1'b0;
        end else if (cnt == period_m1(speed_q)) begin
            cnt   <= '0;
            bps_q <= 1'b1;
        end else begin
            cnt   <= cnt + 1'b1;
            bps_q <= 1'b0;
        end
    end

    assign bus.clk_bps   = bps_q;
    assign bus.dir       = dir_q;
    assign bus.speed_lvl = speed_q;

endmodule

// File: tb/tb_flash_tick_gen.sv
// Bench for flash_tick_gen: history-window model compared every cycle plus directed timing checks.
module tb_flash_tick_gen;

    localparam int DEB = 4;
    localparam int P_TAB [4] = '{8, 6, 4, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;

    flash_tick_gen_if bus();

    flash_tick_gen #(
        .DEB_CYCLES (DEB),
        .PERIOD0    (8),
        .PERIOD1    (6),
        .PERIOD2    (4),
        .PERIOD3    (2),
        .CNT_W      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: raw sample history (bit j = sample j edges ago), accepted levels,
    // press events waiting out their two-cycle pipeline, and cycles since last restart.
    logic [DEB+1:0] hd = '0;
    logic [DEB+1:0] hs = '0;
    bit m_stab_d, m_stab_s;
    bit rd1, rd2, rs1, rs2;
    bit e_bps, e_dir;
    int e_spd = 0;
    int since = 0;

    function automatic bit window_is(input logic [DEB+1:0] h, input bit v);
        for (int j = 2; j <= DEB + 1; j++)
            if (h[j] != v) return 1'b0;
        return 1'b1;
    endfunction

    initial begin : model
        bit rise_d, rise_s, act_d, act_s;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                hd = '0; hs = '0;
                m_stab_d = 0; m_stab_s = 0;
                rd1 = 0; rd2 = 0; rs1 = 0; rs2 = 0;
                e_bps = 0; e_dir = 0; e_spd = 0; since = 0;
            end else begin
                hd = {hd[DEB:0], bus.btn_dir};
                hs = {hs[DEB:0], bus.btn_speed};
                rise_d = 0;
                rise_s = 0;
                if (window_is(hd, !m_stab_d)) begin
                    rise_d   = !m_stab_d;
                    m_stab_d = !m_stab_d;
                end
                if (window_is(hs, !m_stab_s)) begin
                    rise_s   = !m_stab_s;
                    m_stab_s = !m_stab_s;
                end
                act_d = rd2; rd2 = rd1; rd1 = rise_d;
                act_s = rs2; rs2 = rs1; rs1 = rise_s;
                if (bus.power_now && act_d) e_dir = !e_dir;
                if (!bus.power_now) begin
                    since = 0;
                    e_bps = 0;
                end else if (act_s) begin
                    e_spd = (e_spd + 1) % 4;
                    since = 0;
                    e_bps = 0;
                end else begin
                    since++;
                    e_bps = ((since % P_TAB[e_spd]) == 0);
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("cmp_bps", int'(bus.clk_bps), int'(e_bps));
            chk("cmp_dir", int'(bus.dir), int'(e_dir));
            chk("cmp_spd", int'(bus.speed_lvl), e_spd);
        end
    end

    // sel 0: wait for clk_bps; 1: wait for dir change; 2: wait for speed_lvl change.
    // n = number of falling edges until seen, or -1 on timeout.
    task automatic wait_sig(input int sel, input int maxc, output int n);
        logic       old_dir;
        logic [1:0] old_spd;
        bit         hit;
        old_dir = bus.dir;
        old_spd = bus.speed_lvl;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = bus.clk_bps;
                1:       hit = (bus.dir != old_dir);
                default: hit = (bus.speed_lvl != old_spd);
            endcase
            if (hit) return;
            if (n >= maxc) begin
                n = -1;
                return;
            end
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin : stim
        int n;
        int nb;
        int spacing [4] = '{6, 4, 2, 8};
        bus.btn_dir   = 1'b0;
        bus.btn_speed = 1'b0;
        bus.power_now = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_bps", int'(bus.clk_bps), 0);
        chk("rst_dir", int'(bus.dir), 0);
        chk("rst_spd", int'(bus.speed_lvl), 0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            wait_sig(0, 20, n);
            chk("tick_period0", n, 8);
        end

        bus.btn_dir = 1'b1;
        wait_sig(1, 20, n);
        chk("dir_latency", n, 8);
        chk("dir_left", int'(bus.dir), 1);
        repeat (2) @(negedge clk);
        bus.btn_dir = 1'b0;
        repeat (12) @(negedge clk);
        chk("dir_no_retoggle", int'(bus.dir), 1);
        bus.btn_dir = 1'b1;
        wait_sig(1, 20, n);
        chk("dir_latency2", n, 8);
        chk("dir_right", int'(bus.dir), 0);
        repeat (2) @(negedge clk);
        bus.btn_dir = 1'b0;
        repeat (12) @(negedge clk);

        bus.btn_speed = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn_speed = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_spd", int'(bus.speed_lvl), 0);

        for (int i = 0; i < 4; i++) begin
            bus.btn_speed = 1'b1;
            wait_sig(2, 20, n);
            chk("spd_latency", n, 8);
            chk("spd_value", int'(bus.speed_lvl), (i + 1) % 4);
            wait_sig(0, 20, n);
            chk("spd_spacing", n, spacing[i]);
            bus.btn_speed = 1'b0;
            repeat (10) @(negedge clk);
        end

        bus.power_now = 1'b0;
        bus.btn_dir   = 1'b1;
        nb = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.clk_bps) nb++;
        end
        chk("off_no_bps", nb, 0);
        chk("off_dir_kept", int'(bus.dir), 0);
        bus.power_now = 1'b1;
        wait_sig(0, 20, n);
        chk("powerup_tick", n, 8);
        bus.btn_dir = 1'b0;
        repeat (10) @(negedge clk);
        chk("powerup_no_event", int'(bus.dir), 0);

        bus.btn_dir = 1'b1;
        wait_sig(1, 20, n);
        chk("dir_before_rst", int'(bus.dir), 1);
        repeat (2) @(negedge clk);
        bus.btn_dir = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bus.btn_speed = 1'b1;
            wait_sig(2, 20, n);
            repeat (2) @(negedge clk);
            bus.btn_speed = 1'b0;
            repeat (10) @(negedge clk);
        end
        chk("spd_before_rst", int'(bus.speed_lvl), 2);

        wait_sig(0, 20, n);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_bps", int'(bus.clk_bps), 0);
        chk("async_rst_dir", int'(bus.dir), 0);
        chk("async_rst_spd", int'(bus.speed_lvl), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_sig(0, 20, n);
        chk("post_rst_tick", n, 8);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
